gemm_psum_accumulator: RTL

Downstream neighbour of the MAC vector/adder-tree stage. It accumulates the stream of signed dot-product partial sums, one per N-element chunk, over cfg_num_chunks chunks to form one GEMM output element. It then requantizes the element (rounding right shift plus saturation) and delivers it to the write-back path through a 2-entry output buffer with valid/ready handshaking.

---
 rtl/gemm_pkg.sv | 19 +
 rtl/gemm_out_fifo2.sv | 58 +++++
 rtl/gemm_psum_accumulator.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
// Shared types and sizes for the GEMM partial-sum accumulator slice.
package gemm_pkg;

  localparam int unsigned WIDTH        = 16;
  localparam int unsigned ACC_W        = 40;
  localparam int unsigned K_CHUNKS_MAX = 64;
  localparam int unsigned OUT_W        = 16;
  localparam int unsigned CNT_W        = $clog2(K_CHUNKS_MAX + 1);

  typedef logic signed [2*WIDTH-1:0] psum_t;
  typedef logic signed [ACC_W-1:0]   acc_t;
  typedef logic signed [OUT_W-1:0]   out_t;

  typedef struct packed {
    out_t data;
    logic sat;
  } res_t;

endpackage

// File: rtl/gemm_out_fifo2.sv
// Two-entry result FIFO. A push into a full FIFO is dropped even when a pop
// happens in the same cycle (no bypass); push and pop otherwise coexist.
module gemm_out_fifo2
  import gemm_pkg::*;
#(
  parameter type T = res_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  T           mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push_ok;
  logic       pop_ok;

  // Flags and qualified push/pop, evaluated against the pre-pop occupancy
  always_comb begin
    full    = (count == 2'd2);
    empty   = (count == 2'd0);
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    head    = mem[rd_ptr];
  end

  // Storage, pointers and occupancy update
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gemm_psum_accumulator.sv
// Accumulates signed dot-product partial sums over a group of chunks,
// requantizes (round-half-up right shift + saturation) and queues the result
// in a 2-entry output buffer. Optional macro GEMM_ACC_BIAS_EN adds a
// bias_data port folded into the first beat of each group.
module gemm_psum_accumulator #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned ACC_W        = 40,
  parameter int unsigned K_CHUNKS_MAX = 64,
  parameter int unsigned OUT_W        = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [$clog2(K_CHUNKS_MAX+1)-1:0]      cfg_num_chunks,
  input  logic [4:0]                             cfg_shift,
  input  logic                                   psum_valid,
  output logic                                   psum_ready,
  input  logic [2*WIDTH-1:0]                     psum_data,
`ifdef GEMM_ACC_BIAS_EN
  input  logic [2*WIDTH-1:0]                     bias_data,
`endif
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [OUT_W-1:0]                       out_data,
  output logic                                   out_sat,
  output logic                                   busy
);

  import gemm_pkg::*;

  localparam int unsigned PSUM_W = 2 * WIDTH;
  localparam int unsigned CW     = $clog2(K_CHUNKS_MAX + 1);

  // Saturation bounds expressed in the widened (ACC_W+1) rounding domain
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef struct packed {
    logic signed [OUT_W-1:0] data;
    logic                    sat;
  } entry_t;

  logic        [CW-1:0]    chunk_cnt;
  logic        [CW-1:0]    num_q;
  logic        [4:0]       shift_q;
  logic signed [ACC_W-1:0] acc;

  logic        [CW-1:0]    num_live;
  logic        [CW-1:0]    num_eff;
  logic        [4:0]       shift_eff;
  logic                    first;
  logic                    is_final;
  logic                    accept;
  logic                    push;
  logic signed [ACC_W-1:0] psum_ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W:0]   sum_w;
  logic signed [ACC_W:0]   rnd;
  logic signed [ACC_W:0]   rounded;
  entry_t                  res;
  entry_t                  head;
  logic                    full;
  logic                    empty;

  // Group control, accumulate path and requantization of the final sum
  always_comb begin
    num_live  = (cfg_num_chunks == '0) ? CW'(1) : cfg_num_chunks;
    first     = (chunk_cnt == '0);
    // Live cfg governs the first beat; latched cfg governs the rest of the group
    num_eff   = first ? num_live : num_q;
    shift_eff = first ? cfg_shift : shift_q;
    is_final  = (chunk_cnt == num_eff - CW'(1));

    psum_ready = !(full && is_final);
    accept     = psum_valid && psum_ready;
    push       = accept && is_final;

    psum_ext = {{(ACC_W - PSUM_W){psum_data[PSUM_W-1]}}, psum_data};
`ifdef GEMM_ACC_BIAS_EN
    base = first ? {{(ACC_W - PSUM_W){bias_data[PSUM_W-1]}}, bias_data} : acc;
`else
    base = first ? '0 : acc;
`endif
    sum = base + psum_ext;

    // One extra bit keeps the rounding increment from wrapping
    sum_w = {sum[ACC_W-1], sum};
    rnd   = '0;
    if (shift_eff != 5'd0) begin
      rnd = {{ACC_W{1'b0}}, 1'b1} << (shift_eff - 5'd1);
    end
    rounded = (sum_w + rnd) >>> shift_eff;

    res = '0;
    if (rounded > SAT_MAX) begin
      res.data = SAT_MAX[OUT_W-1:0];
      res.sat  = 1'b1;
    end else if (rounded < SAT_MIN) begin
      res.data = SAT_MIN[OUT_W-1:0];
      res.sat  = 1'b1;
    end else begin
      res.data = rounded[OUT_W-1:0];
    end
  end

  // Accumulator, chunk counter and per-group config latch
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc       <= '0;
      chunk_cnt <= '0;
      num_q     <= CW'(1);
      shift_q   <= '0;
    end else if (accept) begin
      if (first) begin
        num_q   <= num_live;
        shift_q <= cfg_shift;
      end
      if (is_final) begin
        acc       <= '0;
        chunk_cnt <= '0;
      end else begin
        acc       <= sum;
        chunk_cnt <= chunk_cnt + CW'(1);
      end
    end
  end

  gemm_out_fifo2 #(
    .T(entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (res),
    .pop       (out_ready),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // Output view of the buffer head and activity flag
  always_comb begin
    out_valid = !empty;
    out_data  = head.data;
    out_sat   = head.sat;
    busy      = (chunk_cnt != '0) || !empty;
  end

endmodule
